stream_uart_tx: RTL and testbench

Parametrised byte-stream-to-UART transmitter that terminates the AXI-Stream style output (tdata/tlast/tvalid/tready) of the SoC aggregation core. It is the successor to the fixed-format emitter. Additions:
- configurable data width, baud rate, parity and stop bits
- an input FIFO so the producer is not stalled per character
- optional automatic end-of-line insertion on tlast
Sits at the chip top between the core's stream output and the board UART pin.

---
 rtl/stream_uart_pkg.sv | 42 ++++
 rtl/stream_uart_tx_if.sv | 18 +
 rtl/stream_uart_fifo.sv | 76 +++++++
 rtl/stream_uart_tx.sv | 206 ++++++++++++++++++++
 tb/tb_stream_uart_tx.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stream_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stream_uart_pkg
// Brief    : Shared types, constants and helpers for the stream UART transmitter
// Revision : 1.0 - initial release
// ============================================================================
package stream_uart_pkg;

    // Transmit FSM encoding
    typedef logic [2:0] state_t;
    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_START  = 3'd1;
    localparam state_t S_DATA   = 3'd2;
    localparam state_t S_PARITY = 3'd3;
    localparam state_t S_STOP   = 3'd4;
    localparam state_t S_EOL_CR = 3'd5;
    localparam state_t S_EOL_LF = 3'd6;

    // What the frame currently on the line carries
    typedef logic [1:0] kind_t;
    localparam kind_t K_CHAR = 2'd0;
    localparam kind_t K_CR   = 2'd1;
    localparam kind_t K_LF   = 2'd2;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    localparam int EOL_NONE = 0;
    localparam int EOL_LF   = 1;
    localparam int EOL_CRLF = 2;

    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;

    // Clocks per bit, rounded to nearest
    function automatic int calc_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stream_uart_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : stream_uart_tx_if
// Brief    : Byte-stream handshake bundle (tdata/tlast/tvalid/tready)
// Revision : 1.0 - initial release
// ============================================================================
interface stream_uart_tx_if #(
    parameter int DATA_BITS = 8
) ();
    logic [DATA_BITS-1:0] tdata;
    logic                 tlast;
    logic                 tvalid;
    logic                 tready;

    modport master (output tdata, output tlast, output tvalid, input tready);
    modport slave  (input tdata, input tlast, input tvalid, output tready);
endinterface
`default_nettype wire

// File: rtl/stream_uart_fifo.sv
`default_nettype none
// ============================================================================
// Module   : stream_uart_fifo
// Brief    : Synchronous FIFO with registered full/empty and occupancy level
// Revision : 1.0 - initial release
// ============================================================================
module stream_uart_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16
) (
    input  wire                      i_clk,
    input  wire                      i_rst_n,
    input  wire                      i_push,
    input  wire [WIDTH-1:0]          i_data,
    input  wire                      i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);
    localparam int c_aw = $clog2(DEPTH);
    localparam int c_lw = c_aw + 1;
    localparam logic [c_lw-1:0] c_one   = c_lw'(1);
    localparam logic [c_lw-1:0] c_depth = c_lw'(DEPTH);
    localparam logic [c_aw-1:0] c_ptr_one = c_aw'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr, r_rd_ptr;
    logic [c_lw-1:0]  r_level, w_level_nxt;
    logic             r_full, r_empty;
    logic             w_push_ok, w_pop_ok;

    assign w_push_ok = i_push && !r_full;
    assign w_pop_ok  = i_pop && !r_empty;

    // Next occupancy; push and pop together leave it unchanged
    always_comb begin
        w_level_nxt = r_level;
        case ({w_push_ok, w_pop_ok})
            2'b10:   w_level_nxt = r_level + c_one;
            2'b01:   w_level_nxt = r_level - c_one;
            default: w_level_nxt = r_level;
        endcase
    end

    // Storage array, no reset needed since contents are qualified by level
    always_ff @(posedge i_clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + c_ptr_one;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
            r_level <= w_level_nxt;
            r_full  <= (w_level_nxt == c_depth);
            r_empty <= (w_level_nxt == '0);
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_full  = r_full;
    assign o_empty = r_empty;
    assign o_level = r_level;

endmodule
`default_nettype wire

// File: rtl/stream_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : stream_uart_tx
// Brief    : Byte stream to UART transmitter with input FIFO and optional
//            end-of-line insertion after a character flagged with tlast
// Revision : 1.0 - initial release
// ============================================================================
module stream_uart_tx
    import stream_uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 16000000,
    parameter int BAUD        = 57600,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1,
    parameter int DEPTH       = 16,
    parameter int EOL_MODE    = 0
) (
    input  wire                      i_clk,
    input  wire                      i_rst_n,
    stream_uart_tx_if.slave          s_axis,
    output logic                     o_uart_tx,
    output logic                     o_busy,
    output logic [$clog2(DEPTH):0]   o_level
);
    localparam int c_div   = calc_div(CLK_FREQ_HZ, BAUD);
    localparam int c_cnt_w = $clog2(c_div);
    localparam logic [c_cnt_w-1:0]   c_cnt_max  = c_cnt_w'(c_div - 1);
    localparam logic [c_cnt_w-1:0]   c_cnt_one  = c_cnt_w'(1);
    localparam logic [3:0]           c_last_dat = 4'(DATA_BITS - 1);
    localparam logic [3:0]           c_last_stp = 4'(STOP_BITS - 1);
    localparam logic [DATA_BITS-1:0] c_cr       = DATA_BITS'(CHAR_CR);
    localparam logic [DATA_BITS-1:0] c_lf       = DATA_BITS'(CHAR_LF);

    generate
        if (c_div < 4 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY > 2 ||
            STOP_BITS < 1 || STOP_BITS > 2 || EOL_MODE > 2 ||
            DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_params
            $error("stream_uart_tx: illegal parameter combination");
        end
    endgenerate

    function automatic logic f_parity(input logic [DATA_BITS-1:0] d);
        return (PARITY == PARITY_ODD) ? ~^d : ^d;
    endfunction

    logic [DATA_BITS:0]   w_head;
    logic                 w_full, w_empty, w_push, w_pop, w_tready;
    logic                 r_started;
    state_t               r_state;
    kind_t                r_kind;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [3:0]           r_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par, r_last, r_tx, r_busy;
    logic                 w_line, w_cnt_zero, w_stop_last, w_to_eol;

    stream_uart_fifo #(
        .WIDTH (DATA_BITS + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_push),
        .i_data  ({s_axis.tlast, s_axis.tdata}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (o_level)
    );

    // Holds tready low through reset and releases it on the first clean edge
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_started <= 1'b0;
        else          r_started <= 1'b1;
    end

    assign w_tready      = r_started && !w_full;
    assign s_axis.tready = w_tready;
    assign w_push        = s_axis.tvalid && w_tready;

    assign w_cnt_zero  = (r_cnt == '0);
    assign w_stop_last = (r_bit == c_last_stp);
    assign w_to_eol    = (r_kind == K_CR) ||
                         (r_kind == K_CHAR && r_last && EOL_MODE != EOL_NONE);
    // Characters are pulled when idle, or back-to-back at the end of a stop bit
    assign w_pop = !w_empty &&
                   ((r_state == S_IDLE) ||
                    (r_state == S_STOP && w_cnt_zero && w_stop_last && !w_to_eol));

    // Line level implied by the current state
    always_comb begin
        w_line = 1'b1;
        case (r_state)
            S_START:  w_line = 1'b0;
            S_DATA:   w_line = r_shift[0];
            S_PARITY: w_line = r_par;
            default:  w_line = 1'b1;
        endcase
    end

    // Frame sequencer: baud down-counter, bit shifter and registered line/busy.
    // Ahead of an EOL frame the last stop bit ends one cycle early; the one-cycle
    // EOL load state drives high, so the stop time stays exactly STOP_BITS*DIV.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_kind  <= K_CHAR;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_last  <= 1'b0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            r_tx   <= w_line;
            r_busy <= (r_state != S_IDLE) || (o_level != '0);
            if (w_pop) begin
                r_shift <= w_head[DATA_BITS-1:0];
                r_last  <= w_head[DATA_BITS];
                r_par   <= f_parity(w_head[DATA_BITS-1:0]);
                r_kind  <= K_CHAR;
                r_cnt   <= c_cnt_max;
                r_state <= S_START;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_cnt <= '0;
                    end
                    S_START: begin
                        if (w_cnt_zero) begin
                            r_state <= S_DATA;
                            r_bit   <= '0;
                            r_cnt   <= c_cnt_max;
                        end else begin
                            r_cnt <= r_cnt - c_cnt_one;
                        end
                    end
                    S_DATA: begin
                        if (w_cnt_zero) begin
                            r_cnt   <= c_cnt_max;
                            r_shift <= r_shift >> 1;
                            if (r_bit == c_last_dat) begin
                                r_bit   <= '0;
                                r_state <= (PARITY != PARITY_NONE) ? S_PARITY : S_STOP;
                            end else begin
                                r_bit <= r_bit + 4'd1;
                            end
                        end else begin
                            r_cnt <= r_cnt - c_cnt_one;
                        end
                    end
                    S_PARITY: begin
                        if (w_cnt_zero) begin
                            r_state <= S_STOP;
                            r_bit   <= '0;
                            r_cnt   <= c_cnt_max;
                        end else begin
                            r_cnt <= r_cnt - c_cnt_one;
                        end
                    end
                    S_STOP: begin
                        if (w_stop_last && w_to_eol && r_cnt == c_cnt_one) begin
                            r_cnt   <= '0;
                            r_state <= (r_kind == K_CHAR && EOL_MODE == EOL_CRLF) ?
                                       S_EOL_CR : S_EOL_LF;
                        end else if (w_cnt_zero) begin
                            if (!w_stop_last) begin
                                r_bit <= r_bit + 4'd1;
                                r_cnt <= c_cnt_max;
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end else begin
                            r_cnt <= r_cnt - c_cnt_one;
                        end
                    end
                    S_EOL_CR: begin
                        r_shift <= c_cr;
                        r_par   <= f_parity(c_cr);
                        r_kind  <= K_CR;
                        r_cnt   <= c_cnt_max;
                        r_state <= S_START;
                    end
                    S_EOL_LF: begin
                        r_shift <= c_lf;
                        r_par   <= f_parity(c_lf);
                        r_kind  <= K_LF;
                        r_cnt   <= c_cnt_max;
                        r_state <= S_START;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_uart_tx = r_tx;
    assign o_busy    = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_stream_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_uart_tx
// Brief    : Directed self-checking bench; instance A is 8N1 with a 4-deep
//            FIFO, instance B is 7O2 with CR LF insertion. Both run DIV = 8.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stream_uart_tx;
    localparam int c_period = 10;
    localparam int c_bit_t  = 8 * c_period;
    localparam int c_ofs    = c_bit_t / 2 + c_period / 2;

    logic       clk, rst_n;
    logic       tx_a, busy_a, tx_b, busy_b;
    logic [2:0] level_a, level_b;

    stream_uart_tx_if #(.DATA_BITS(8)) a_if ();
    stream_uart_tx_if #(.DATA_BITS(7)) b_if ();

    stream_uart_tx #(
        .CLK_FREQ_HZ (8000000), .BAUD (1000000), .DATA_BITS (8), .PARITY (0),
        .STOP_BITS (1), .DEPTH (4), .EOL_MODE (0)
    ) dut_a (
        .i_clk (clk), .i_rst_n (rst_n), .s_axis (a_if),
        .o_uart_tx (tx_a), .o_busy (busy_a), .o_level (level_a)
    );

    stream_uart_tx #(
        .CLK_FREQ_HZ (8000000), .BAUD (1000000), .DATA_BITS (7), .PARITY (1),
        .STOP_BITS (2), .DEPTH (4), .EOL_MODE (2)
    ) dut_b (
        .i_clk (clk), .i_rst_n (rst_n), .s_axis (b_if),
        .o_uart_tx (tx_b), .o_busy (busy_b), .o_level (level_b)
    );

    initial clk = 1'b0;
    always #(c_period / 2) clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] qa_data[$];
    time        qa_t0[$];
    bit         qa_ok[$];
    logic [7:0] qb_data[$];
    bit         qb_ok[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Line decoder for instance A: start, 8 data LSB first, 1 stop
    initial begin : mon_a
        logic [7:0] d;
        logic       sb, pb;
        time        t0;
        forever begin
            @(negedge tx_a);
            t0 = $time;
            #(c_ofs);
            sb = tx_a;
            for (int k = 0; k < 8; k++) begin
                #(c_bit_t);
                d[k] = tx_a;
            end
            #(c_bit_t);
            pb = tx_a;
            qa_data.push_back(d);
            qa_t0.push_back(t0);
            qa_ok.push_back(sb == 1'b0 && pb == 1'b1);
        end
    end

    // Line decoder for instance B: start, 7 data, odd parity, 2 stop
    initial begin : mon_b
        logic [6:0] d;
        logic       sb, pb, s1, s2;
        forever begin
            @(negedge tx_b);
            #(c_ofs);
            sb = tx_b;
            for (int k = 0; k < 7; k++) begin
                #(c_bit_t);
                d[k] = tx_b;
            end
            #(c_bit_t); pb = tx_b;
            #(c_bit_t); s1 = tx_b;
            #(c_bit_t); s2 = tx_b;
            qb_data.push_back({1'b0, d});
            qb_ok.push_back(sb == 1'b0 && pb == ~^d && s1 && s2);
        end
    end

    task automatic send(input bit sel, input logic [7:0] d, input logic l);
        int guard = 0;
        @(negedge clk);
        if (sel) begin b_if.tdata = d[6:0]; b_if.tlast = l; b_if.tvalid = 1'b1; end
        else     begin a_if.tdata = d;      a_if.tlast = l; a_if.tvalid = 1'b1; end
        while (((sel ? b_if.tready : a_if.tready) !== 1'b1) && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        chk("send_accept", 32'(guard < 2000), 1);
        @(negedge clk);
        if (sel) b_if.tvalid = 1'b0; else a_if.tvalid = 1'b0;
    endtask

    task automatic wait_rx(input bit sel, input int n, input int budget);
        int c = 0;
        while (((sel ? qb_data.size() : qa_data.size()) < n) && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk(sel ? "rx_count_b" : "rx_count_a", 32'(c < budget), 1);
    endtask

    task automatic wait_low(input bit sel, input int budget);
        int c = 0;
        while (((sel ? tx_b : tx_a) !== 1'b0) && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk("start_seen", 32'(c < budget), 1);
    endtask

    initial begin : watchdog
        #(500000);
        $display("FAIL watchdog: time limit reached before the bench completed");
        $fatal(1, "bench stopped by watchdog");
    end

    initial begin : main
        logic [7:0]  v;
        logic [10:0] fr;
        logic [7:0]  burst [10];
        logic        cap_tx [90];
        logic        cap_bz [90];
        logic        e;
        int          mism, idx, guard, viol, highs, lows;
        bit          go, saw_full;

        burst = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF, 8'h5A, 8'hC3};

        // Reset held with tvalid asserted: nothing may be accepted
        rst_n = 1'b0;
        a_if.tvalid = 1'b1; a_if.tdata = 8'hEE; a_if.tlast = 1'b0;
        b_if.tvalid = 1'b1; b_if.tdata = 7'h2A; b_if.tlast = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rst_tx_a",  tx_a, 1);
            chk("rst_rdy_a", a_if.tready, 0);
            chk("rst_lvl_a", level_a, 0);
            chk("rst_rdy_b", b_if.tready, 0);
            chk("rst_lvl_b", level_b, 0);
        end
        rst_n = 1'b1;
        a_if.tvalid = 1'b0;
        b_if.tvalid = 1'b0;
        @(negedge clk);
        chk("rel_rdy_a",  a_if.tready, 1);
        chk("rel_rdy_b",  b_if.tready, 1);
        chk("rel_busy_a", busy_a, 0);
        chk("rel_tx_b",   tx_b, 1);

        // Single 0x55 on A, cycle-exact waveform from the accepting edge
        qa_data.delete(); qa_t0.delete(); qa_ok.delete();
        v = 8'h55;
        a_if.tdata = v; a_if.tlast = 1'b0; a_if.tvalid = 1'b1;
        chk("t2_ready", a_if.tready, 1);
        @(negedge clk);
        a_if.tvalid = 1'b0;
        for (int i = 0; i < 84; i++) begin
            cap_tx[i] = tx_a;
            cap_bz[i] = busy_a;
            @(negedge clk);
        end
        mism = 0;
        for (int i = 0; i < 84; i++) begin
            if (i < 2)       e = 1'b1;
            else if (i < 10) e = 1'b0;
            else if (i < 74) e = v[(i - 10) / 8];
            else             e = 1'b1;
            if (cap_tx[i] !== e) mism++;
        end
        chk("t2_wave_mism", mism, 0);
        chk("t2_tx_n1",  cap_tx[1], 1);
        chk("t2_tx_n2",  cap_tx[2], 0);
        chk("t2_tx_d0",  cap_tx[10], 1);
        chk("t2_tx_d1",  cap_tx[18], 0);
        chk("t2_busy_stop", cap_bz[81], 1);
        chk("t2_busy_end",  cap_bz[82], 0);
        chk("t2_decode", qa_data[0], 8'h55);

        // Back-to-back frames on A: exactly 80 cycles apart
        qa_data.delete(); qa_t0.delete(); qa_ok.delete();
        send(0, 8'hA5, 0);
        send(0, 8'h3C, 0);
        send(0, 8'hFF, 0);
        wait_rx(0, 3, 400);
        chk("t3_b0", qa_data[0], 8'hA5);
        chk("t3_b1", qa_data[1], 8'h3C);
        chk("t3_b2", qa_data[2], 8'hFF);
        chk("t3_fmt", 32'(qa_ok[0] && qa_ok[1] && qa_ok[2]), 1);
        chk("t3_gap01", 32'(qa_t0[1] - qa_t0[0]), 10 * c_bit_t);
        chk("t3_gap12", 32'(qa_t0[2] - qa_t0[1]), 10 * c_bit_t);
        repeat (20) @(negedge clk);

        // Burst of 10 with tvalid held high against a 4-deep FIFO
        qa_data.delete(); qa_t0.delete(); qa_ok.delete();
        idx = 0; guard = 0; viol = 0; saw_full = 1'b0;
        a_if.tdata = burst[0]; a_if.tlast = 1'b0; a_if.tvalid = 1'b1;
        while (idx < 10 && guard < 3000) begin
            go = a_if.tready;
            if (level_a == 3'd4 && a_if.tready) viol++;
            if (level_a == 3'd4 && !a_if.tready) saw_full = 1'b1;
            @(negedge clk);
            guard++;
            if (go) begin
                idx++;
                if (idx < 10) a_if.tdata = burst[idx];
                else          a_if.tvalid = 1'b0;
            end
        end
        a_if.tvalid = 1'b0;
        chk("t4_all_accepted", idx, 10);
        chk("t4_ready_when_full", viol, 0);
        chk("t4_reached_full", 32'(saw_full), 1);
        wait_rx(0, 10, 1500);
        repeat (100) @(negedge clk);
        chk("t4_count", qa_data.size(), 10);
        mism = 0;
        for (int i = 0; i < 10; i++) begin
            if (qa_data[i] !== burst[i] || !qa_ok[i]) mism++;
        end
        chk("t4_order_mism", mism, 0);

        // 7O2 frame of 0x41 on B: parity 1, 16 stop cycles
        fr = {1'b1, 1'b1, 1'b1, 7'h41, 1'b0};
        send(1, 8'h41, 0);
        wait_low(1, 10);
        for (int i = 0; i < 89; i++) begin
            cap_tx[i] = tx_b;
            @(negedge clk);
        end
        mism = 0;
        highs = 0;
        for (int i = 0; i < 89; i++) begin
            e = (i < 88) ? fr[i / 8] : 1'b1;
            if (cap_tx[i] !== e) mism++;
            if (i >= 72 && i < 88 && cap_tx[i] === 1'b1) highs++;
        end
        chk("t5_wave_mism", mism, 0);
        chk("t5_parity", cap_tx[68], 1);
        chk("t5_d6", cap_tx[60], 1);
        chk("t5_stop_high", highs, 16);

        // CR LF insertion after tlast on B
        repeat (10) @(negedge clk);
        qb_data.delete(); qb_ok.delete();
        send(1, 8'h48, 1);
        wait_rx(1, 3, 600);
        chk("t6_b0", qb_data[0], 8'h48);
        chk("t6_cr", qb_data[1], 8'h0D);
        chk("t6_lf", qb_data[2], 8'h0A);
        chk("t6_fmt", 32'(qb_ok[0] && qb_ok[1] && qb_ok[2]), 1);

        // Reset in the middle of the data bits of a following byte
        repeat (20) @(negedge clk);
        send(1, 8'h33, 0);
        send(1, 8'h22, 0);
        wait_low(1, 20);
        repeat (30) @(negedge clk);
        chk("t6_pre_lvl", level_b, 1);
        chk("t6_pre_busy", busy_b, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6_rst_tx",  tx_b, 1);
        chk("t6_rst_lvl", level_b, 0);
        chk("t6_rst_rdy", b_if.tready, 0);
        chk("t6_rst_busy", busy_b, 0);
        rst_n = 1'b1;
        lows = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (tx_b !== 1'b1) lows++;
        end
        chk("t6_no_resume", lows, 0);
        chk("t6_post_lvl", level_b, 0);
        chk("t6_post_busy", busy_b, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
